wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_stage_load_ext.sv | 30 +++
 rtl/wb_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage types: load funct3 encodings and the load-queue entry layout.
package wb_pkg;

  localparam int WB_DATA_WIDTH = 64;
  localparam int WB_RF_SIZE    = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Queue entries are sized by the package widths; the stage is built with matching parameters.
  typedef struct packed {
    logic [WB_RF_SIZE-1:0]    rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } lq_entry_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load-data extractor: shifts the addressed field down and sign/zero-extends it.
module load_ext
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            funct3_i,
  input  logic [2:0]            byte_off_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] field;

  assign field = data_i >> {byte_off_i, 3'b000};

  always_comb begin
    data_o = field;
    unique case (funct3_i)
      F3_LB:   data_o = {{(DATA_WIDTH-8){field[7]}}, field[7:0]};
      F3_LH:   data_o = {{(DATA_WIDTH-16){field[15]}}, field[15:0]};
      F3_LW:   data_o = {{(DATA_WIDTH-32){field[31]}}, field[31:0]};
      F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, field[7:0]};
      F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, field[15:0]};
      F3_LWU:  data_o = {{(DATA_WIDTH-32){1'b0}}, field[31:0]};
      default: data_o = field;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage arbitrating ALU results against a small queue of extended load results.
// Define WB_SCOREBOARD_EN to drive pending_mask_o from the queued load destinations.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5,
  parameter int LQ_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid_i,
  output logic                      alu_ready_o,
  input  logic [RF_SIZE-1:0]        alu_rd_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [RF_SIZE-1:0]        lsu_rd_i,
  input  logic [2:0]                lsu_funct3_i,
  input  logic [2:0]                lsu_byte_off_i,
  input  logic [DATA_WIDTH-1:0]     lsu_data_i,
  output logic                      gpr_we_o,
  output logic [RF_SIZE-1:0]        gpr_rd_o,
  output logic [DATA_WIDTH-1:0]     gpr_data_o,
  output logic [(2**RF_SIZE)-1:0]   pending_mask_o
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  lq_entry_t               lq_mem_q [LQ_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    gpr_we_q, gpr_we_d;
  logic [RF_SIZE-1:0]      gpr_rd_q, gpr_rd_d;
  logic [DATA_WIDTH-1:0]   gpr_data_q, gpr_data_d;

  logic                    full, push, pop, sel_lq, sel_alu;
  logic [RF_SIZE-1:0]      sel_rd;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [DATA_WIDTH-1:0]   ext_data;
  lq_entry_t               head;

  load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .funct3_i   (lsu_funct3_i),
    .byte_off_i (lsu_byte_off_i),
    .data_i     (lsu_data_i),
    .data_o     (ext_data)
  );

  assign head = lq_mem_q[rd_ptr_q];
  assign full = (count_q == FULL_CNT);

  // Readies come from the registered count only; rst_n gates them low while reset is held.
  assign alu_ready_o = rst_n & ~full;
  assign lsu_ready_o = rst_n & ~full;

  always_comb begin
    push       = lsu_valid_i & lsu_ready_o;
    sel_lq     = full | (~alu_valid_i & (count_q != '0));
    sel_alu    = ~full & alu_valid_i;
    pop        = sel_lq;
    sel_rd     = sel_lq ? head.rd : alu_rd_i;
    sel_data   = sel_lq ? head.data : alu_data_i;
    // Writes to x0 are consumed but never reach the register file.
    gpr_we_d   = (sel_lq | sel_alu) & (sel_rd != '0);
    gpr_rd_d   = gpr_we_d ? sel_rd : gpr_rd_q;
    gpr_data_d = gpr_we_d ? sel_data : gpr_data_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gpr_we_q   <= 1'b0;
      gpr_rd_q   <= '0;
      gpr_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gpr_we_q   <= gpr_we_d;
      gpr_rd_q   <= gpr_rd_d;
      gpr_data_q <= gpr_data_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem_q[wr_ptr_q] <= '{rd: lsu_rd_i, data: ext_data};
    end
  end

  assign gpr_we_o   = gpr_we_q;
  assign gpr_rd_o   = gpr_rd_q;
  assign gpr_data_o = gpr_data_q;

`ifdef WB_SCOREBOARD_EN
  logic [PW-1:0] slot_age [LQ_DEPTH];

  for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_slot_age
    assign slot_age[gi] = PW'(gi) - rd_ptr_q;
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if ({1'b0, slot_age[i]} < count_q) begin
        pending_mask_o[lq_mem_q[i].rd] = 1'b1;
      end
    end
    pending_mask_o[0] = 1'b0;
  end
`else
  assign pending_mask_o = '0;
`endif

endmodule
